dmem_port_arbiter: RTL and testbench

//   Two-requester arbiter sharing the SoC's single-port synchronous data memory (MEM).

---
 rtl/dmem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous data memory.
// R0 is the core data bus, R1 the debug/boot-loader port. Each access takes one
// issue cycle (IDLE, memory strobed combinationally) and one acknowledge cycle (BUSY).
module dmem_port_arbiter #(
   parameter int unsigned AW         = 11,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic          CLK,
   input  logic          RES,

   input  logic          R0_REQ,
   input  logic          R0_WR,
   input  logic [3:0]    R0_BE,
   input  logic [AW-1:0] R0_ADDR,
   input  logic [31:0]   R0_WDATA,
   output logic          R0_ACK,
   output logic [31:0]   R0_RDATA,

   input  logic          R1_REQ,
   input  logic          R1_WR,
   input  logic [3:0]    R1_BE,
   input  logic [AW-1:0] R1_ADDR,
   input  logic [31:0]   R1_WDATA,
   output logic          R1_ACK,
   output logic [31:0]   R1_RDATA,

   output logic          M_EN,
   output logic [3:0]    M_WE,
   output logic [AW-1:0] M_ADDR,
   output logic [31:0]   M_WDATA,
   input  logic [31:0]   M_RDATA,

   output logic [1:0]    GNT
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StBusy = 1'b1;

   logic [0:0] state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic       wr_q, wr_d;
   logic       ack_q, ack_d;
   logic [1:0] gnt_q, gnt_d;

   logic       any_req;
   logic       win;
   logic       win_wr;
   logic [3:0] win_be;
   logic       issue;

   // Pick the winner among current requesters and drive the memory port from it.
   always_comb begin
      any_req = R0_REQ | R1_REQ;
      if (R0_REQ && R1_REQ) begin
         // Round-robin hands the tie to whoever was not served last.
         win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
      end else begin
         win = R1_REQ;
      end
      win_wr  = win ? R1_WR : R0_WR;
      win_be  = win ? R1_BE : R0_BE;
      issue   = (state_q == StIdle) && any_req && !RES;
      M_EN    = issue;
      M_WE    = (issue && win_wr) ? win_be : 4'h0;
      M_ADDR  = win ? R1_ADDR : R0_ADDR;
      M_WDATA = win ? R1_WDATA : R0_WDATA;
   end

   // Next-state logic: IDLE issues and captures the winner, BUSY acknowledges for one cycle.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      wr_d    = wr_q;
      gnt_d   = gnt_q;
      ack_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d = StBusy;
               owner_d = win;
               last_d  = win;
               wr_d    = win_wr;
               gnt_d   = win ? 2'b10 : 2'b01;
               ack_d   = 1'b1;
            end
         end
         StBusy: begin
            // Requests are ignored here; a held REQ is re-arbitrated in the next IDLE.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset favours R0 on the first tie by marking R1 as last served.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         state_q <= StIdle;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         wr_q    <= 1'b0;
         ack_q   <= 1'b0;
         gnt_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
         ack_q   <= ack_d;
         gnt_q   <= gnt_d;
      end
   end

   // Return path: only the owner sees ACK and read data; writes return zero.
   always_comb begin
      R0_ACK   = ack_q & ~owner_q;
      R1_ACK   = ack_q & owner_q;
      R0_RDATA = (R0_ACK && !wr_q) ? M_RDATA : 32'h0;
      R1_RDATA = (R1_ACK && !wr_q) ? M_RDATA : 32'h0;
      GNT      = gnt_q;
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a round-robin instance is checked against a reference
// memory and a scoreboard of expected acknowledges; a fixed-priority instance shares
// the stimulus and is checked on its acknowledge counts.
module tb_dmem_port_arbiter;

   typedef struct {
      logic        r0;
      logic        r1;
      logic        wr0;
      logic        wr1;
      logic [3:0]  be0;
      logic [3:0]  be1;
      logic [10:0] a0;
      logic [10:0] a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        exp_en;
      logic        exp_w;
      logic [3:0]  exp_we;
   } vec_t;

   typedef struct packed {
      logic        who;
      logic [31:0] rdata;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RES;
   logic        ld;
   logic        r0_req, r0_wr, r1_req, r1_wr;
   logic [3:0]  r0_be, r1_be;
   logic [10:0] r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata;

   logic        r0_ack, r1_ack, m_en;
   logic [31:0] r0_rdata, r1_rdata, m_wdata, m_rdata;
   logic [3:0]  m_we;
   logic [10:0] m_addr;
   logic [1:0]  gnt;

   logic        fp_r0_ack, fp_r1_ack, fp_m_en;
   logic [31:0] fp_r0_rdata, fp_r1_rdata, fp_m_wdata, fp_m_rdata;
   logic [3:0]  fp_m_we;
   logic [10:0] fp_m_addr;
   logic [1:0]  fp_gnt;

   logic [31:0] mem_a [0:2047];
   logic [31:0] mem_b [0:2047];
   logic [31:0] ref_mem [0:2047];

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   na0, na1, fa0, fa1;
   vec_t vecs [10];

   always #5 CLK = ~CLK;

   dmem_port_arbiter #(.AW(11), .FIXED_PRIO(0)) dut (
      .CLK(CLK), .RES(RES),
      .R0_REQ(r0_req), .R0_WR(r0_wr), .R0_BE(r0_be), .R0_ADDR(r0_addr),
      .R0_WDATA(r0_wdata), .R0_ACK(r0_ack), .R0_RDATA(r0_rdata),
      .R1_REQ(r1_req), .R1_WR(r1_wr), .R1_BE(r1_be), .R1_ADDR(r1_addr),
      .R1_WDATA(r1_wdata), .R1_ACK(r1_ack), .R1_RDATA(r1_rdata),
      .M_EN(m_en), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata),
      .M_RDATA(m_rdata), .GNT(gnt)
   );

   dmem_port_arbiter #(.AW(11), .FIXED_PRIO(1)) dut_fp (
      .CLK(CLK), .RES(RES),
      .R0_REQ(r0_req), .R0_WR(r0_wr), .R0_BE(r0_be), .R0_ADDR(r0_addr),
      .R0_WDATA(r0_wdata), .R0_ACK(fp_r0_ack), .R0_RDATA(fp_r0_rdata),
      .R1_REQ(r1_req), .R1_WR(r1_wr), .R1_BE(r1_be), .R1_ADDR(r1_addr),
      .R1_WDATA(r1_wdata), .R1_ACK(fp_r1_ack), .R1_RDATA(fp_r1_rdata),
      .M_EN(fp_m_en), .M_WE(fp_m_we), .M_ADDR(fp_m_addr), .M_WDATA(fp_m_wdata),
      .M_RDATA(fp_m_rdata), .GNT(fp_gnt)
   );

   function automatic logic [31:0] init_word(input logic [10:0] a);
      if (a == 11'h010) return 32'hDEADBEEF;
      if (a == 11'h004) return 32'hFFFFFFFF;
      return {5'b10101, a, 5'b01010, a};
   endfunction

   // Synchronous single-port memories, one per DUT instance.
   always @(posedge CLK) begin
      if (ld) begin
         for (int i = 0; i < 2048; i++) begin
            mem_a[i] <= init_word(i[10:0]);
            mem_b[i] <= init_word(i[10:0]);
         end
      end else begin
         if (m_en) begin
            for (int b = 0; b < 4; b++)
               if (m_we[b]) mem_a[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            if (m_we == 4'h0) m_rdata <= mem_a[m_addr];
         end
         if (fp_m_en) begin
            for (int b = 0; b < 4; b++)
               if (fp_m_we[b]) mem_b[fp_m_addr][8*b +: 8] <= fp_m_wdata[8*b +: 8];
            if (fp_m_we == 4'h0) fp_m_rdata <= mem_b[fp_m_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Scoreboard side: pop and compare whenever an acknowledge is visible.
   task automatic observe();
      exp_t e;
      if (fp_r0_ack) fa0++;
      if (fp_r1_ack) fa1++;
      if (r0_ack && r1_ack) chk("dual_ack", 32'(r1_ack), 32'(1'b0));
      if (r0_ack || r1_ack) begin
         if (r0_ack) na0++;
         else na1++;
         if (sb.size() == 0) begin
            chk("unexpected_ack", {r1_ack, r0_ack}, 32'h0);
         end else begin
            e = sb.pop_front();
            chk("ack_owner", 32'(r1_ack), 32'(e.who));
            chk("rdata", r1_ack ? r1_rdata : r0_rdata, e.rdata);
            chk("nonowner_rdata", r1_ack ? r0_rdata : r1_rdata, 32'h0);
         end
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      observe();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input vec_t v);
      r0_req = v.r0;  r0_wr = v.wr0; r0_be = v.be0; r0_addr = v.a0; r0_wdata = v.d0;
      r1_req = v.r1;  r1_wr = v.wr1; r1_be = v.be1; r1_addr = v.a1; r1_wdata = v.d1;
   endtask

   // One arbitration slot: check the issue cycle, push the expected result, run 2 cycles.
   task automatic do_vec(input vec_t v);
      logic        wr;
      logic [3:0]  be;
      logic [10:0] a;
      logic [31:0] d;
      exp_t        e;
      drive(v);
      #1;
      chk("m_en", 32'(m_en), 32'(v.exp_en));
      if (v.exp_en) begin
         wr = v.exp_w ? v.wr1 : v.wr0;
         be = v.exp_w ? v.be1 : v.be0;
         a  = v.exp_w ? v.a1 : v.a0;
         d  = v.exp_w ? v.d1 : v.d0;
         chk("m_we", 32'(m_we), 32'(v.exp_we));
         chk("m_addr", 32'(m_addr), 32'(a));
         chk("m_wdata", m_wdata, d);
         e.who   = v.exp_w;
         e.rdata = wr ? 32'h0 : ref_mem[a];
         sb.push_back(e);
         if (wr)
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end
      tick();
      if (v.exp_en) chk("gnt", 32'(gnt), v.exp_w ? 32'h2 : 32'h1);
      r0_req = 1'b0;
      r1_req = 1'b0;
      tick();
   endtask

   initial begin
      exp_t e;
      // r0 r1 wr0 wr1 be0 be1 a0 a1 d0 d1 exp_en exp_w exp_we
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 11'h010, 11'h000,
                  32'h0, 32'h0, 1'b1, 1'b0, 4'h0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h3, 11'h000, 11'h004,
                  32'h0, 32'h12345678, 1'b1, 1'b1, 4'h3};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 11'h004, 11'h000,
                  32'h0, 32'h0, 1'b1, 1'b0, 4'h0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 11'h010, 11'h000,
                  32'h0, 32'h0, 1'b1, 1'b0, 4'h0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 11'h010, 11'h000,
                  32'h0, 32'h0, 1'b1, 1'b0, 4'h0};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 11'h020, 11'h030,
                  32'h0, 32'h0, 1'b1, 1'b1, 4'h0};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 11'h020, 11'h030,
                  32'h0, 32'h0, 1'b1, 1'b0, 4'h0};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 11'h000, 11'h7FF,
                  32'h0, 32'hCAFEF00D, 1'b1, 1'b1, 4'hF};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 11'h000, 11'h7FF,
                  32'h0, 32'h0, 1'b1, 1'b1, 4'h0};
      vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 11'h111, 11'h222,
                  32'h0, 32'h0, 1'b0, 1'b0, 4'h0};

      for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i[10:0]);
      na0 = 0; na1 = 0; fa0 = 0; fa1 = 0;

      // Reset with a write request pending: memory port and return path must stay quiet.
      RES = 1'b1; ld = 1'b1;
      r0_req = 1'b1; r0_wr = 1'b1; r0_be = 4'hF; r0_addr = 11'h010; r0_wdata = 32'h0;
      r1_req = 1'b0; r1_wr = 1'b0; r1_be = 4'h0; r1_addr = 11'h0;   r1_wdata = 32'h0;
      #1;
      chk("rst_m_en", 32'(m_en), 32'h0);
      chk("rst_m_we", 32'(m_we), 32'h0);
      chk("rst_acks", {r1_ack, r0_ack}, 32'h0);
      chk("rst_rdata", r0_rdata | r1_rdata, 32'h0);
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      ld = 1'b0;
      r0_req = 1'b0;
      tick();
      RES = 1'b0;

      for (int i = 0; i < 10; i++) do_vec(vecs[i]);

      // Both requesters held for 8 slots; RR alternates starting with R0, FP serves R0 only.
      na0 = 0; na1 = 0; fa0 = 0; fa1 = 0;
      for (int k = 0; k < 8; k++) begin
         e.who   = k[0];
         e.rdata = k[0] ? ref_mem[11'h050] : ref_mem[11'h040];
         sb.push_back(e);
      end
      r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 11'h040;
      r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 11'h050;
      for (int c = 0; c < 16; c++) tick();
      r0_req = 1'b0; r1_req = 1'b0;
      chk("rr_r0_acks", 32'(na0), 32'd4);
      chk("rr_r1_acks", 32'(na1), 32'd4);
      chk("fp_r0_acks", 32'(fa0), 32'd8);
      chk("fp_r1_acks", 32'(fa1), 32'd0);

      // Reset during BUSY: ACK drops at once, the access is discarded, R0 wins next tie.
      r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 11'h060;
      tick();
      chk("busy_ack", 32'(r0_ack), 32'h1);
      #1;
      RES = 1'b1;
      #1;
      chk("midrst_ack", {r1_ack, r0_ack}, 32'h0);
      chk("midrst_rdata", r0_rdata, 32'h0);
      chk("midrst_m_en", 32'(m_en), 32'h0);
      chk("midrst_gnt", 32'(gnt), 32'h0);
      r0_req = 1'b0;
      tick();
      RES = 1'b0;
      do_vec(vecs[6]);

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
